// File: rtl/fifo_flush_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_flush_pkg
//  Purpose  : Shared nibble/word types and helpers for the nibble FIFOs.
//  Revision : 1.0  initial release
// ============================================================================
package fifo_flush_pkg;

    localparam int NIB_W     = 4;
    localparam int WORD_NIBS = 8;
    localparam int WORD_W    = NIB_W * WORD_NIBS;

    typedef logic [NIB_W-1:0]  nib_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [3:0]        nib_cnt_t;

    typedef struct packed {
        nib_cnt_t cnt;
        word_t    data;
    } slot_t;

    function automatic logic cnt_ok(input nib_cnt_t cnt);
        return (cnt >= 4'd1) && (cnt <= 4'(WORD_NIBS));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_word_mem.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_word_mem
//  Purpose  : DEPTH x {cnt,data} slot storage, synchronous write, async read.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_word_mem
    import fifo_flush_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  slot_t                    i_wr_slot,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output slot_t                    o_rd_slot
);

    slot_t r_mem [DEPTH];

    // Contents survive reset and flush; only the owning pointers are cleared.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_slot;
        end
    end

    assign o_rd_slot = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/fifo_unpack_nibble.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_unpack_nibble
//  Purpose  : Width-down FIFO: 32-bit words with nibble counts in, nibbles out.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_unpack_nibble
    import fifo_flush_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     fifo_wr_valid_i,
    input  word_t    fifo_wr_data_i,
    input  nib_cnt_t fifo_wr_cnt_i,
    input  logic     fifo_rd_valid_i,
    input  logic     fifo_flush_i,
    output nib_t     fifo_rd_data_o,
    output logic     fifo_rd_vld_o,
    output logic     fifo_rd_last_o,
    output logic     fifo_empty_o,
    output logic     fifo_full_o
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    c_full_cnt = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [2:0]    r_nib_idx;
    nib_t          r_rd_data;
    logic          r_rd_vld;
    logic          r_rd_last;

    logic  w_full;
    logic  w_empty;
    logic  w_wr_acc;
    logic  w_rd_acc;
    logic  w_last;
    logic  w_retire;
    nib_t  w_nib;
    slot_t w_head;
    slot_t w_wr_slot;

    assign w_full    = (r_count == c_full_cnt);
    assign w_empty   = (r_count == '0);
    assign w_wr_acc  = fifo_wr_valid_i & ~w_full & cnt_ok(fifo_wr_cnt_i) & ~fifo_flush_i;
    assign w_rd_acc  = fifo_rd_valid_i & ~w_empty & ~fifo_flush_i;
    assign w_wr_slot = '{cnt: fifo_wr_cnt_i, data: fifo_wr_data_i};

    fifo_word_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clock),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wptr),
        .i_wr_slot (w_wr_slot),
        .i_rd_addr (r_rptr),
        .o_rd_slot (w_head)
    );

    // Stored counts are always 1..8, so cnt-1 never underflows.
    assign w_last   = ({1'b0, r_nib_idx} == (w_head.cnt - 4'd1));
    assign w_retire = w_rd_acc & w_last;
    assign w_nib    = w_head.data[NIB_W*r_nib_idx +: NIB_W];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_nib_idx <= '0;
            r_rd_data <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
        end else if (fifo_flush_i) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_nib_idx <= '0;
            r_rd_data <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + AW'(1);
            end

            if (w_rd_acc) begin
                r_rd_data <= w_nib;
                r_rd_vld  <= 1'b1;
                r_rd_last <= w_last;
                if (w_last) begin
                    r_nib_idx <= '0;
                    r_rptr    <= r_rptr + AW'(1);
                end else begin
                    r_nib_idx <= r_nib_idx + 3'd1;
                end
            end else begin
                r_rd_vld  <= 1'b0;
                r_rd_last <= 1'b0;
            end

            case ({w_wr_acc, w_retire})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign fifo_rd_data_o = r_rd_data;
    assign fifo_rd_vld_o  = r_rd_vld;
    assign fifo_rd_last_o = r_rd_last;
    assign fifo_empty_o   = w_empty;
    assign fifo_full_o    = w_full;

endmodule
`default_nettype wire
